branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
Fetch-side counterpart to the branch prediction unit. It carries each fetched instruction's prediction (taken flag and predicted target) down the IF→ID→EX pipeline alongside the instruction. In EX it compares that prediction against the actual outcome, then drives the flush, the redirect PC (over a valid/ready handshake with fetch) and the predictor update strobe. It sits between the fetch stage, the predictor and the EX-stage branch/jump logic.

Parameters:
PC_W, 32, width of PC and target fields
CNT_W, 32, width of performance counters (used only with BRU_PERF_EN)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
IF_valid  in  1  IF stage holds a real instruction this cycle
IF_pc  in  PC_W  PC of the IF instruction
IF_predict_taken  in  1  predictor's taken flag for IF_pc
IF_target_address_predict  in  PC_W  predictor's target for IF_pc
stall_pipeline  in  1  freezes IF→ID and ID→EX metadata advance
stall_execute  in  1  EX result not final this cycle
EX_pc  in  PC_W  PC of the instruction in EX
EX_is_ctrl  in  1  EX instruction is br/jal/jalr
EX_taken  in  1  actual outcome (pcmux select is not pc_plus4)
EX_target_pc  in  PC_W  actual target computed in EX
redirect_ready  in  1  fetch accepts the redirect this cycle
flush  out  1  squash IF and ID stages
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  PC_W  corrected fetch PC
update_valid  out  1  resolved control instruction; predictor may write
EX_pred_taken  out  1  prediction carried to EX for the current EX instruction
EX_pred_target  out  PC_W  predicted target carried to EX
mispredict  out  1  EX mispredict this cycle
branch_count  out  CNT_W  resolved control instructions (BRU_PERF_EN only)
mispredict_count  out  CNT_W  mispredicts (BRU_PERF_EN only)

Behaviour:
- Metadata registers ID_meta and EX_meta, each {v, pc, taken, target}.
  - When not stalled and not flushing: ID_meta ← {IF_valid, IF_pc, IF_predict_taken, IF_target_address_predict}, and EX_meta ← ID_meta.
  - stall_pipeline=1: both registers hold.
- meta_ok = EX_meta.v && EX_meta.pc==EX_pc. If meta_ok=0, the effective prediction is not-taken with target 0.
- EX_pred_taken = meta_ok & EX_meta.taken; EX_pred_target = meta_ok ? EX_meta.target : 0. Both are combinational.
- resolve = state==RUN && !stall_execute && (EX_is_ctrl || EX_pred_taken).
- mispredict = resolve && any of:
  - EX_is_ctrl && EX_taken != EX_pred_taken
  - EX_is_ctrl && EX_taken && EX_target_pc != EX_pred_target
  - !EX_is_ctrl && EX_pred_taken (alias hit on a non-control instruction)
- Correct-PC value: EX_is_ctrl && EX_taken ? EX_target_pc : EX_pc+4. The add is mod 2^PC_W; wrap at 0xFFFFFFFC gives 0.
- update_valid = resolve && EX_is_ctrl. It is combinational and asserted once per resolved instruction.
- FSM, two states: RUN and PEND.
  - RUN: on mispredict, pulse flush for one cycle, clear ID_meta.v and EX_meta.v, and latch redirect_pc. If redirect_ready=1 the same cycle, stay in RUN; otherwise go to PEND.
  - PEND: redirect_valid=1 and redirect_pc is held stable. IF_valid is ignored (ID_meta.v forced 0). No resolve occurs. On redirect_ready, return to RUN.
  - redirect_valid is asserted in the mispredict cycle (combinational from the mispredict) and in every PEND cycle.
- Simultaneous stall_pipeline and mispredict: flush wins, and metadata valids clear regardless of the stall.
- stall_execute=1 suppresses mispredict, flush and update_valid. They evaluate again once the stall drops.
- Reset: state=RUN; ID_meta and EX_meta all zero; redirect_pc=0. All outputs are 0, including the counters.
- Reset asserted during PEND returns to RUN with redirect_valid=0 the next cycle.

Optional Feature:
BRU_PERF_EN
- Defined: branch_count increments on each update_valid cycle, and mispredict_count on each mispredict cycle. Both saturate at all-ones and clear on reset.
- Undefined: no counter registers are built; both ports are tied to 0.

Test Plan:
1. Correctly predicted branch. IF_pc=0x100, IF_predict_taken=1, target 0x200. Two cycles later EX_pc=0x100, EX_is_ctrl=1, EX_taken=1, EX_target_pc=0x200 → update_valid=1, mispredict=0, flush=0, redirect_valid=0.
2. Taken-but-predicted-not-taken. EX_pc=0x40, EX_taken=1, target 0x80, prediction not-taken, redirect_ready=1 → flush=1 and redirect_valid=1 for 1 cycle, redirect_pc=0x80; the next EX cycle sees EX_meta.v=0.
3. Wrong target. Predicted taken to 0x300, actual taken to 0x340 at EX_pc=0x10 → mispredict=1, redirect_pc=0x340.
4. Alias hit on a non-branch. EX_is_ctrl=0, predicted taken, EX_pc=0xFFFFFFFC → mispredict=1, redirect_pc=0x00000000, update_valid=0.
5. Handshake hold. Mispredict with redirect_ready=0 for 3 cycles → redirect_valid stays 1 and redirect_pc stays stable. IF_valid pulses are ignored. Ready on cycle 4 → state returns to RUN and redirect_valid=0 the next cycle.
6. Stalls and reset. stall_execute=1 over a would-be mispredict → no flush until the stall drops. With BRU_PERF_EN, 5 resolved branches with 2 mispredicts → branch_count=5, mispredict_count=2; rst mid-PEND clears everything.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Carries branch predictions IF->ID->EX, resolves them in EX, and drives flush/redirect/update.
// Optional perf counters are built only when BRU_PERF_EN is defined.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_valid,
  input  logic [PC_W-1:0]  IF_pc,
  input  logic             IF_predict_taken,
  input  logic [PC_W-1:0]  IF_target_address_predict,
  input  logic             stall_pipeline,
  input  logic             stall_execute,
  input  logic [PC_W-1:0]  EX_pc,
  input  logic             EX_is_ctrl,
  input  logic             EX_taken,
  input  logic [PC_W-1:0]  EX_target_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             update_valid,
  output logic             EX_pred_taken,
  output logic [PC_W-1:0]  EX_pred_target,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef struct packed {
    logic            v;
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } meta_t;

  typedef enum logic {RUN, PEND} state_e;

  state_e          state_q, state_d;
  meta_t           id_meta_q, id_meta_d, ex_meta_q, ex_meta_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [PC_W-1:0] correct_pc;
  logic            meta_ok, resolve;

  always_comb begin
    // A stale or mismatched EX record degrades to a not-taken prediction.
    meta_ok        = ex_meta_q.v && (ex_meta_q.pc == EX_pc);
    EX_pred_taken  = meta_ok & ex_meta_q.taken;
    EX_pred_target = meta_ok ? ex_meta_q.target : '0;
    resolve        = (state_q == RUN) && !stall_execute && (EX_is_ctrl || EX_pred_taken);
    mispredict     = resolve && ((EX_is_ctrl && (EX_taken != EX_pred_taken)) ||
                                 (EX_is_ctrl && EX_taken && (EX_target_pc != EX_pred_target)) ||
                                 (!EX_is_ctrl && EX_pred_taken));
    update_valid   = resolve && EX_is_ctrl;
    correct_pc     = (EX_is_ctrl && EX_taken) ? EX_target_pc : EX_pc + PC_W'(4);
    flush          = mispredict;
    redirect_valid = mispredict || (state_q == PEND);
    redirect_pc    = mispredict ? correct_pc : redirect_pc_q;

    state_d       = state_q;
    id_meta_d     = id_meta_q;
    ex_meta_d     = ex_meta_q;
    redirect_pc_d = redirect_pc_q;

    if (mispredict) begin
      // Flush overrides a concurrent stall_pipeline.
      id_meta_d.v   = 1'b0;
      ex_meta_d.v   = 1'b0;
      redirect_pc_d = correct_pc;
      state_d       = redirect_ready ? RUN : PEND;
    end else begin
      if (!stall_pipeline) begin
        id_meta_d.v      = IF_valid && (state_q == RUN);
        id_meta_d.pc     = IF_pc;
        id_meta_d.taken  = IF_predict_taken;
        id_meta_d.target = IF_target_address_predict;
        ex_meta_d        = id_meta_q;
      end
      if (state_q == PEND && redirect_ready) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      id_meta_q     <= '0;
      ex_meta_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      id_meta_q     <= id_meta_d;
      ex_meta_q     <= ex_meta_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

`ifdef BRU_PERF_EN
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  // Saturating counters: stop at all-ones.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_valid && !(&branch_count_q))   branch_count_d     = branch_count_q + CNT_W'(1);
    if (mispredict && !(&mispredict_count_q)) mispredict_count_d = mispredict_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule
